// File: rtl/lsu_pkg.sv
// Shared types and error cause codes for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LSU_ERR_NONE  = 3'd0;
    localparam logic [2:0] LSU_ERR_SIZE  = 3'd1;
    localparam logic [2:0] LSU_ERR_ALIGN = 3'd2;
    localparam logic [2:0] LSU_ERR_RANGE = 3'd3;
    localparam logic [2:0] LSU_ERR_FSIZE = 3'd4;
    localparam logic [2:0] LSU_ERR_RMW   = 3'd5;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake plus I-port and F-port memory buses of the load/store controller.
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_is_f;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_is_f;
    logic        rsp_err;

    logic        mem_enable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] mem_data_out;

    logic        mem_enable_f_out_mem;
    logic        mem_write_f_out_mem;
    logic [31:0] address_f;
    logic [31:0] data_for_writing_sw;
    logic [31:0] mem_data_out_f;

    // Controller side.
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_is_f, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_data, rsp_is_f, rsp_err,
        input  rsp_ready,
        output mem_enable, mem_read, mem_write, address, write_data,
        input  mem_data_out,
        output mem_enable_f_out_mem, mem_write_f_out_mem, address_f, data_for_writing_sw,
        input  mem_data_out_f
    );

    // Pipeline and memory side.
    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_is_f, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_is_f, rsp_err,
        output rsp_ready,
        input  mem_enable, mem_read, mem_write, address, write_data,
        output mem_data_out,
        input  mem_enable_f_out_mem, mem_write_f_out_mem, address_f, data_for_writing_sw,
        output mem_data_out_f
    );

endinterface

// File: rtl/lsu_lane.sv
// Byte/half lane extraction with sign/zero extension, and (with LSU_RMW_EN) sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
`ifdef LSU_RMW_EN
    input  logic [15:0] new_data,
    output logic [31:0] merged,
`endif
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {lane, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        load_data = word;
        case (size)
            BYTE:    load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            HALF:    load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = word;
        endcase
    end

`ifdef LSU_RMW_EN
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        mask   = (size == BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        ins    = (size == BYTE) ? {24'h0, new_data[7:0]} : {16'h0, new_data};
        merged = (word & ~(mask << shamt)) | (ins << shamt);
    end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for the RV32IF data memory; I-port for integer, F-port for float accesses.
// Optional LSU_RMW_EN enables read-modify-write sub-word stores; otherwise they are rejected.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    lsu_ctrl_if.slave bus
);

    lsu_state_e  state_q;
    lsu_size_e   req_size;
    lsu_size_e   size_q;
    logic        uns_q;
    logic        is_f_q;
    logic [1:0]  lane_q;
`ifdef LSU_RMW_EN
    logic        store_q;
    logic [15:0] wdata_q;
    logic [31:0] merged;
`endif

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_is_f_q;
    logic        rsp_err_q;
    logic        en_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_out_q;
    logic        en_f_q;
    logic        wr_f_q;
    logic [31:0] addr_f_q;
    logic [31:0] data_f_q;

    logic [2:0]  err_cause;
    logic        out_of_range;
    logic [31:0] word_addr;
    logic [31:0] rdata;
    logic [31:0] load_data;

    assign req_size     = lsu_size_e'(bus.req_size);
    assign word_addr    = {{(32 - AW){1'b0}}, bus.req_addr[AW+1:2]};
    assign out_of_range = bus.req_addr[31:2] >= 30'(DEPTH_WORDS);
    assign rdata        = is_f_q ? bus.mem_data_out_f : bus.mem_data_out;

    always_comb begin
        err_cause = LSU_ERR_NONE;
        if (bus.req_size == 2'd3) begin
            err_cause = LSU_ERR_SIZE;
        end else if ((req_size == HALF && bus.req_addr[0]) ||
                     (req_size == WORD && bus.req_addr[1:0] != 2'b00)) begin
            err_cause = LSU_ERR_ALIGN;
        end else if (out_of_range) begin
            err_cause = LSU_ERR_RANGE;
        end else if (bus.req_is_f && req_size != WORD) begin
            err_cause = LSU_ERR_FSIZE;
`ifndef LSU_RMW_EN
        end else if (bus.req_store && req_size != WORD) begin
            err_cause = LSU_ERR_RMW;
`endif
        end
    end

    lsu_lane u_lane (
        .word       (rdata),
        .lane       (lane_q),
        .size       (size_q),
        .is_unsigned(uns_q),
`ifdef LSU_RMW_EN
        .new_data   (wdata_q),
        .merged     (merged),
`endif
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            is_f_q      <= 1'b0;
            lane_q      <= 2'b00;
`ifdef LSU_RMW_EN
            store_q     <= 1'b0;
            wdata_q     <= '0;
`endif
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_is_f_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            en_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_out_q <= '0;
            en_f_q      <= 1'b0;
            wr_f_q      <= 1'b0;
            addr_f_q    <= '0;
            data_f_q    <= '0;
        end else begin
            // Memory controls live for exactly one state, so they default to idle every edge.
            en_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_out_q <= '0;
            en_f_q      <= 1'b0;
            wr_f_q      <= 1'b0;
            addr_f_q    <= '0;
            data_f_q    <= '0;

            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (err_cause != LSU_ERR_NONE) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_is_f_q  <= bus.req_is_f;
                        end else begin
                            size_q  <= req_size;
                            uns_q   <= bus.req_unsigned;
                            is_f_q  <= bus.req_is_f;
                            lane_q  <= bus.req_addr[1:0];
`ifdef LSU_RMW_EN
                            store_q <= bus.req_store;
                            wdata_q <= bus.req_wdata[15:0];
`endif
                            if (bus.req_store && req_size == WORD) begin
                                state_q <= WR;
                                if (bus.req_is_f) begin
                                    en_f_q   <= 1'b1;
                                    wr_f_q   <= 1'b1;
                                    addr_f_q <= word_addr;
                                    data_f_q <= bus.req_wdata;
                                end else begin
                                    en_q        <= 1'b1;
                                    wr_q        <= 1'b1;
                                    addr_q      <= word_addr;
                                    wdata_out_q <= bus.req_wdata;
                                end
                            end else begin
                                state_q <= RD;
                                if (bus.req_is_f) begin
                                    en_f_q   <= 1'b1;
                                    addr_f_q <= word_addr;
                                end else begin
                                    en_q   <= 1'b1;
                                    rd_q   <= 1'b1;
                                    addr_q <= word_addr;
                                end
                            end
                        end
                    end
                end
                RD: begin
`ifdef LSU_RMW_EN
                    if (store_q) begin
                        state_q     <= WR;
                        en_q        <= 1'b1;
                        wr_q        <= 1'b1;
                        addr_q      <= addr_q;
                        wdata_out_q <= merged;
                    end else
`endif
                    begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= load_data;
                        rsp_is_f_q  <= is_f_q;
                        rsp_err_q   <= 1'b0;
                    end
                end
                WR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_is_f_q  <= is_f_q;
                    rsp_err_q   <= 1'b0;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_is_f_q  <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready            = req_ready_q;
    assign bus.rsp_valid            = rsp_valid_q;
    assign bus.rsp_data             = rsp_data_q;
    assign bus.rsp_is_f             = rsp_is_f_q;
    assign bus.rsp_err              = rsp_err_q;
    assign bus.mem_enable           = en_q;
    assign bus.mem_read             = rd_q;
    assign bus.mem_write            = wr_q;
    assign bus.address              = addr_q;
    assign bus.write_data           = wdata_out_q;
    assign bus.mem_enable_f_out_mem = en_f_q;
    assign bus.mem_write_f_out_mem  = wr_f_q;
    assign bus.address_f            = addr_f_q;
    assign bus.data_for_writing_sw  = data_f_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a byte-addressed reference memory model.
module tb_lsu_ctrl;

    logic clk;
    logic rst_n;

    lsu_ctrl_if bus ();

    lsu_ctrl #(
        .DEPTH_WORDS(256),
        .AW         (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory shared by both ports, asynchronous read, write at the rising edge.
    logic [31:0] mem [256];
    assign bus.mem_data_out   = mem[bus.address[7:0]];
    assign bus.mem_data_out_f = mem[bus.address_f[7:0]];

    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_write) mem[bus.address[7:0]] = bus.write_data;
        if (bus.mem_enable_f_out_mem && bus.mem_write_f_out_mem)
            mem[bus.address_f[7:0]] = bus.data_for_writing_sw;
    end

    // Reference model: plain byte array, little-endian.
    logic [7:0] ref_b [1024];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx] = val;
        for (int k = 0; k < 4; k++) ref_b[4 * idx + k] = val[8 * k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8 * k +: 8] = ref_b[4 * idx + k];
        return w;
    endfunction

    // Bus activity monitor.
    int          mon_en_i = 0;
    int          mon_en_f = 0;
    int          mon_rd   = 0;
    int          mon_wr   = 0;
    logic [31:0] mon_addr  = '0;
    logic [31:0] mon_wdata = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("port_excl", 32'(bus.mem_enable & bus.mem_enable_f_out_mem), 32'h0);
            if (bus.req_ready || bus.rsp_valid)
                chk("quiet", {27'h0, bus.mem_enable, bus.mem_read, bus.mem_write,
                              bus.mem_enable_f_out_mem, bus.mem_write_f_out_mem}
                             | bus.address | bus.write_data | bus.address_f
                             | bus.data_for_writing_sw, 32'h0);
            if (bus.mem_enable) begin
                mon_en_i++;
                mon_addr = bus.address;
                if (bus.mem_read) mon_rd++;
                if (bus.mem_write) begin
                    mon_wr++;
                    mon_wdata = bus.write_data;
                end
            end
            if (bus.mem_enable_f_out_mem) begin
                mon_en_f++;
                mon_addr = bus.address_f;
                if (bus.mem_write_f_out_mem) begin
                    mon_wr++;
                    mon_wdata = bus.data_for_writing_sw;
                end else begin
                    mon_rd++;
                end
            end
        end
    end

    task automatic run_req(input bit st, input int sz, input bit un, input bit isf,
                           input logic [31:0] a, input logic [31:0] wd, input int stall);
        bit          err;
        int          nb, lat, cyc, w, ai, idx;
        int          b_en_i, b_en_f, b_rd, b_wr;
        logic [31:0] exp_data;

        err = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00) ||
              (a >= 32'd1024) || (isf && sz != 2);
`ifndef LSU_RMW_EN
        if (st && sz != 2) err = 1'b1;
`endif
        nb       = (sz < 3) ? (1 << sz) : 4;
        ai       = int'(a[9:0]);
        idx      = ai / 4;
        exp_data = '0;
        if (!err && !st) begin
            for (int k = 0; k < nb; k++) exp_data[8 * k +: 8] = ref_b[ai + k];
            if (!un && nb < 4 && exp_data[8 * nb - 1])
                for (int k = nb; k < 4; k++) exp_data[8 * k +: 8] = 8'hFF;
        end
        if (!err && st)
            for (int k = 0; k < nb; k++) ref_b[ai + k] = wd[8 * k +: 8];
        lat = err ? 1 : ((st && sz < 2) ? 3 : 2);

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_store    = st;
        bus.req_size     = 2'(sz);
        bus.req_unsigned = un;
        bus.req_is_f     = isf;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        w = 0;
        while (!bus.req_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        b_en_i = mon_en_i;
        b_en_f = mon_en_f;
        b_rd   = mon_rd;
        b_wr   = mon_wr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size  = 2'($urandom_range(0, 3));
        cyc = 1;
        while (!bus.rsp_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_err", 32'(bus.rsp_err), 32'(err));
        chk("rsp_is_f", 32'(bus.rsp_is_f), 32'(isf));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
            chk("stall_data", bus.rsp_data, exp_data);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("next_ready", 32'(bus.req_ready), 32'h1);
        chk("rsp_drop", 32'(bus.rsp_valid), 32'h0);

        chk("en_i_cycles", 32'(mon_en_i - b_en_i), (!err && !isf) ? 32'(lat - 1) : 32'h0);
        chk("en_f_cycles", 32'(mon_en_f - b_en_f), (!err && isf) ? 32'(lat - 1) : 32'h0);
        chk("rd_cycles", 32'(mon_rd - b_rd), (!err && (!st || sz < 2)) ? 32'h1 : 32'h0);
        chk("wr_cycles", 32'(mon_wr - b_wr), (!err && st) ? 32'h1 : 32'h0);
        if (!err) chk("mem_addr", mon_addr, 32'(idx));
        if (!err && st) begin
            chk("wr_data", mon_wdata, ref_word(idx));
            chk("mem_word", mem[idx], ref_word(idx));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit          st, un, isf;
        int          sz;
        logic [31:0] a;

        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_is_f     = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
        for (int i = 0; i < 256; i++) set_word(i, $urandom);

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_mem_en", {30'h0, bus.mem_enable, bus.mem_enable_f_out_mem}, 32'h0);
        chk("rst_addr", bus.address | bus.address_f, 32'h0);
        rst_n = 1'b1;

        // Directed scenarios.
        set_word(4, 32'hDEADBEEF);
        run_req(1'b0, 2, 1'b0, 1'b0, 32'h10, 32'h0, 0);
        set_word(4, 32'h80FF_0000);
        run_req(1'b0, 0, 1'b0, 1'b0, 32'h13, 32'h0, 1);
        run_req(1'b0, 0, 1'b1, 1'b0, 32'h13, 32'h0, 0);
        set_word(8, 32'h11223344);
        run_req(1'b1, 0, 1'b0, 1'b0, 32'h21, 32'h0000_00AB, 0);
        run_req(1'b1, 2, 1'b0, 1'b1, 32'h40, 32'h3F80_0000, 0);
        run_req(1'b0, 2, 1'b0, 1'b1, 32'h40, 32'h0, 2);
        run_req(1'b0, 2, 1'b0, 1'b0, 32'h402, 32'h0, 0);
        run_req(1'b0, 2, 1'b0, 1'b0, 32'h400, 32'h0, 0);
        run_req(1'b1, 1, 1'b0, 1'b0, 32'h32, 32'hFFFF_5A5A, 0);
        run_req(1'b0, 1, 1'b0, 1'b0, 32'h32, 32'h0, 0);
        run_req(1'b0, 3, 1'b0, 1'b0, 32'h0, 32'h0, 0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            st  = 1'($urandom_range(0, 1));
            un  = 1'($urandom_range(0, 1));
            isf = ($urandom_range(0, 3) == 0);
            sz  = $urandom_range(0, 5);
            if (sz > 3) sz = 2;
            if (isf && $urandom_range(0, 3) != 0) sz = 2;
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2) a[1:0] = 2'b00;
                if (sz == 1) a[0] = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) a = $urandom;
            run_req(st, sz, un, isf, a, $urandom, $urandom_range(0, 2));
        end

        // Reset during the write cycle of a word store.
        set_word(2, 32'hCAFE_0001);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_store = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_is_f  = 1'b0;
        bus.req_addr  = 32'h8;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_wr_active", 32'(bus.mem_write), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_ctrl", {29'h0, bus.mem_enable, bus.mem_write, bus.mem_read}, 32'h0);
        chk("rst_wr_bus", bus.address | bus.write_data, 32'h0);
        chk("rst_wr_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_wr_rsp", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_wr_mem", mem[2], 32'hCAFE_0001);
        run_req(1'b0, 2, 1'b0, 1'b0, 32'h8, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that initiates all accesses to the dual-port word-addressed data memory on behalf of the RV32IF pipeline. Accepts one byte-addressed request at a time from the execute stage, which can be an integer LB/LH/LW/LBU/LHU/SB/SH/SW or a float FLW/FSW. Checks alignment and range, then drives the memory's I-class port (integer) or F-class port (float). Returns load data or completion status through a valid/ready response channel.

## Interface
- `DEPTH_WORDS`, default 256: memory depth in 32-bit words; must be a power of two.
- `AW`, default 8: word-address width, equal to log2(DEPTH_WORDS).

Ports:
- `clk`, in, 1: single clock; every register is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller accepts a request this cycle.
- `req_store`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_unsigned`, in, 1: zero-extend sub-word loads.
- `req_is_f`, in, 1: float access (FLW/FSW).
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, right-aligned.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: pipeline takes the response.
- `rsp_data`, out, 32: extended load data; 0 for stores and errors.
- `rsp_is_f`, out, 1: echo of `req_is_f`.
- `rsp_err`, out, 1: misaligned, out-of-range or illegal request.
- `mem_enable`, `mem_read`, `mem_write`, out, 1 each: I-port controls.
- `address`, out, 32: I-port word address.
- `write_data`, out, 32: I-port write data.
- `mem_data_out`, in, 32: I-port asynchronous read data.
- `mem_enable_f_out_mem`, `mem_write_f_out_mem`, out, 1 each: F-port controls.
- `address_f`, out, 32: F-port word address.
- `data_for_writing_sw`, out, 32: F-port write data.
- `mem_data_out_f`, in, 32: F-port asynchronous read data.

## Operation
- FSM states: IDLE, RD, WR, RESP.
  - Request capture: `req_ready` = 1 only in IDLE. On `req_valid && req_ready`, the controller registers the request and the lane, `req_addr[1:0]`.
- Error checks, evaluated at capture. On error: go IDLE→RESP, no memory access, `rsp_err` = 1.
  - Size 3.
  - Half at an odd address.
  - Word with `addr[1:0]` ≠ 0.
  - `req_addr[31:AW+2]` ≠ 0 (out of range).
  - `req_is_f` with size ≠ word.
- Word address: {zeros, `req_addr[AW+1:2]`}.
- Load: IDLE→RD→RESP. RD drives enable + read on the selected port and captures read data. The selected lane is extracted and sign- or zero-extended.
- Word store: IDLE→WR→RESP. WR drives enable + write with the data; the memory commits the write at the end of the WR cycle.
- Sub-word store (I-port only): IDLE→RD→WR→RESP.
  - RD captures the old word.
  - WR writes the old word with the byte or half lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
- Port exclusivity: the I-port and F-port enables are never high in the same cycle. Outside RD/WR, all memory controls are 0, addresses are 0 and write data is 0.
- RESP: `rsp_valid` = 1, with `rsp_data`, `rsp_is_f` and `rsp_err` held stable until `rsp_ready`. Then go to IDLE.
- Memory controls are decoded from registered state only, so they are glitch-free.

## Timing
- Reset values: state IDLE, so `req_ready` = 1. All other outputs are 0, and all capture registers are 0.
- Latency from the accept edge to the first `rsp_valid` cycle:
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: one request per (latency + 1) cycles when `rsp_ready` is held high. The next request is accepted in the cycle after the RESP handshake.
- A stalled response (`rsp_ready` low) holds RESP indefinitely, with no memory activity.
- Reset asserted in RD or WR: all controls drop asynchronously, so no write is committed at the next edge and the request is discarded.

## Configuration
- `LSU_RMW_EN` defined: sub-word stores use the RD→WR read-modify-write sequence.
- `LSU_RMW_EN` undefined: sub-word stores are rejected with `rsp_err` = 1 at capture, and the RD-before-WR path is removed. Sub-word loads are unaffected.

## Structure
- `lsu_pkg` holds:
  - The `lsu_size_e` enum (BYTE/HALF/WORD).
  - The `lsu_state_e` enum.
  - The `LSU_ERR_*` cause constants.
- One combinational sub-module, `lsu_lane`, handles lane logic:
  - Load extraction and extension from (word, lane, size, unsigned).
  - Store merge from (old word, new data, lane, size).
- The FSM and capture registers live in `lsu_ctrl`.

## Test plan
- LW at 0x10, memory[4] = 0xDEADBEEF → `address` = 4 with `mem_read` during RD; `rsp_data` = 0xDEADBEEF, 2 cycles after accept.
- LB at 0x13, memory[4] = 0x80FF_0000 → `rsp_data` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SB of 0xAB to 0x21, memory[8] = 0x11223344 (with `LSU_RMW_EN`) → one RD cycle, then WR with `write_data` = 0x1122AB44.
- FSW of 0x3F800000 to 0x40, then FLW from 0x40 → only F-port signals toggle, with `address_f` = 16. The FLW returns 0x3F800000 with `rsp_is_f` = 1.
- LW at 0x0000_0402 and at 0x0000_0400 → both give `rsp_err` = 1 after 1 cycle with no memory enable asserted; the first is misaligned, the second is out of range.
- Assert `rst_n` low in the WR cycle of an SW to 0x8 → memory[2] is unchanged, outputs are 0 and `req_ready` = 1.
